dq_tile_collector: RTL and testbench
====================================

# dq_tile_collector

Sink-side counterpart of the QDQ controller's dequantized output stream. It accepts dequantized FP rows with their global row index. It reassembles `ROWS_PER_TILE` rows into one result tile and checks that the row indices arrive in sequence. It then drains the tile as narrow, lane-serial beats toward the result writer or DMA, and raises a one-cycle tile-done pulse.

## Interface
Parameters:
- `FP_DATA_W`, 32, width of one FP element
- `LANES_NUM`, 16, elements per input row
- `ROW_W`, 4, width of the incoming global row index (wraps modulo 2^ROW_W)
- `ROWS_PER_TILE`, 16, rows per tile; must satisfy 1 ≤ ROWS_PER_TILE ≤ 2^ROW_W
- `OUT_LANES`, 4, elements per output beat; must divide LANES_NUM
- `TILE_CNT_W`, 16, width of the completed-tile counter

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rstnn`  in  1  synchronous, active-low reset
- `clear_i`  in  1  synchronous soft clear; same effect as reset
- `s_valid_i`  in  1  input row valid (connects to `dq_m_valid_o`)
- `s_ready_o`  out  1  input row ready
- `s_data_i`  in  LANES_NUM*FP_DATA_W  row data; lane k sits at bits [k*FP_DATA_W +: FP_DATA_W]
- `s_index_i`  in  ROW_W  global row index
- `m_valid_o`  out  1  output beat valid
- `m_ready_i`  in  1  output beat ready
- `m_data_o`  out  OUT_LANES*FP_DATA_W  beat data; lowest lane in the low bits
- `m_last_o`  out  1  marks the final beat of a tile
- `tile_done_o`  out  1  one-cycle pulse after the last beat of a tile is accepted
- `tile_cnt_o`  out  TILE_CNT_W  count of completed tiles; wraps to 0
- `idx_err_o`  out  1  sticky index-mismatch flag

## Operation
- Storage is a register array of ROWS_PER_TILE × LANES_NUM*FP_DATA_W (one tile, no ping-pong).
- The block has two states: FILL and DRAIN. Reset or clear puts it in FILL.
- FILL behaviour:
  - `s_ready_o`=1 and `m_valid_o`=0.
  - On each handshake, the row is written at slot `wr_row`, which counts 0..ROWS_PER_TILE-1.
  - `wr_row` is a local position counter; `s_index_i` does not address the buffer.
- Index check, on every accepted row:
  - `exp_idx` is a ROW_W-bit counter that starts at 0 and increments by 1 per accepted row, wrapping mod 2^ROW_W.
  - `exp_idx` runs continuously across tiles and is not reset at tile boundaries.
  - If `s_index_i` ≠ `exp_idx`, set `idx_err_o`. The row is still stored at `wr_row`.
  - `idx_err_o` clears only on reset or clear.
- FILL → DRAIN happens on the handshake of the row where `wr_row`=ROWS_PER_TILE-1.
- DRAIN behaviour:
  - `s_ready_o`=0 and `m_valid_o`=1.
  - Order is row-major: `rd_row` runs 0..ROWS_PER_TILE-1; within a row, `rd_beat` runs 0..LANES_NUM/OUT_LANES-1.
  - `m_data_o` = row[`rd_row`] lanes [`rd_beat`*OUT_LANES +: OUT_LANES], muxed directly from the buffer.
  - `m_data_o` must hold stable while `m_valid_o`=1 and `m_ready_i`=0.
  - `m_last_o`=1 only when `rd_row`=ROWS_PER_TILE-1 and `rd_beat`=LANES_NUM/OUT_LANES-1.
- DRAIN → FILL happens on the handshake of the last beat. At that edge:
  - `tile_done_o` is set to 1 for the next cycle only.
  - `tile_cnt_o` increments.
  - `wr_row`, `rd_row` and `rd_beat` return to 0.
- Clear (`clear_i`=1, sampled when `rstnn`=1):
  - Overrides any handshake in the same cycle.
  - Returns to FILL and zeroes all counters and `idx_err_o`.
  - Buffer contents need not be cleared.

## Timing
- Values after reset or clear: `s_ready_o`=1, `m_valid_o`=0, `m_last_o`=0, `tile_done_o`=0, `tile_cnt_o`=0, `idx_err_o`=0.
- Input throughput is one row per cycle in FILL. The first beat appears the cycle after the final row handshake.
- Drain takes ROWS_PER_TILE*LANES_NUM/OUT_LANES beats. With defaults that is 64 beats, one per cycle under continuous ready.
- The cycle after the last-beat handshake:
  - `s_ready_o`=1 and a new row may be accepted.
  - `tile_done_o`=1 in the same cycle.
- Input and output are never active in the same cycle, so there are no simultaneous push/pop cases.
- `s_ready_o` and `m_valid_o` are pure decodes of the state register, with no combinational path from `s_valid_i` or `m_ready_i`.
- `idx_err_o` is set the cycle after the mismatching handshake.
- Reset or clear mid-DRAIN:
  - The partial tile is discarded.
  - `tile_cnt_o` is not incremented and `tile_done_o` does not pulse.

## Test plan
- **Basic tile:** send 16 rows with index 0..15 and lane k of row r = {r[7:0], k[7:0], 16'h0}, ready held high.
  - Expect 64 beats; beat 5 = row 1 lanes 4..7.
  - Expect `m_last_o` only on beat 63, `tile_done_o` one cycle later, `tile_cnt_o`=1 and `idx_err_o`=0.
- **Backpressure:** toggle `m_ready_i` pseudo-randomly during drain.
  - Expect `m_data_o` stable while stalled and all 64 beats in order with no loss or duplication.
- **Index continuity across tiles:** send two tiles with indices 0..15, then 0..15 (wrap).
  - Expect `idx_err_o`=0 and `tile_cnt_o`=2.
- **Index mismatch:** send row 3 with `s_index_i`=5.
  - Expect `idx_err_o`=1 from the next cycle, held through the rest of the tile.
  - Expect the row still drained at position 3.
- **Clear mid-drain:** assert `clear_i` after beat 10.
  - Expect `m_valid_o`=0 and `s_ready_o`=1 next cycle, `tile_cnt_o`=0 and no `tile_done_o`.
  - A fresh tile with indices 0..15 then completes with `idx_err_o`=0.
- **Stall in FILL:** hold `s_valid_i`=0 for 20 cycles after row 7.
  - Expect no output activity until row 15 is accepted; the following drain is correct.

Source files
------------

// File: rtl/dq_tile_collector_if.sv
// dq_tile_collector_if
//   Bundles the two streams around the tile collector: the dequantized row
//   input (s_*) and the lane-serial beat output (m_*).
//   slave  : the collector itself. It accepts rows and presents beats.
//   master : the surrounding environment. It drives rows and the beat ready.
// Signals:
//   s_valid_i / s_ready_o : row handshake
//   s_data_i              : one row, lane k at [k*FP_DATA_W +: FP_DATA_W]
//   s_index_i             : global row index of the row
//   m_valid_o / m_ready_i : beat handshake
//   m_data_o              : one beat, lowest lane in the low bits
//   m_last_o              : final beat of a tile
interface dq_tile_collector_if #(
  parameter int FP_DATA_W = 32,
  parameter int LANES_NUM = 16,
  parameter int ROW_W     = 4,
  parameter int OUT_LANES = 4
);
  logic                           s_valid_i;
  logic                           s_ready_o;
  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i;
  logic [ROW_W-1:0]               s_index_i;
  logic                           m_valid_o;
  logic                           m_ready_i;
  logic [OUT_LANES*FP_DATA_W-1:0] m_data_o;
  logic                           m_last_o;

  modport slave (
    input  s_valid_i, s_data_i, s_index_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o
  );

  modport master (
    output s_valid_i, s_data_i, s_index_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/dq_tile_collector.sv
// dq_tile_collector
//   Collects ROWS_PER_TILE dequantized rows into a one-tile register buffer.
//   It checks that the global row indices arrive in sequence. It then drains
//   the tile row-major as OUT_LANES-wide beats and pulses tile_done_o after
//   the final beat is accepted.
// Ports:
//   clk, rstnn  : clock, synchronous active-low reset
//   clear_i     : synchronous soft clear, same effect as reset
//   bus         : row input / beat output streams (slave modport)
//   tile_done_o : one-cycle pulse after the last beat of a tile is accepted
//   tile_cnt_o  : completed tile counter, wraps
//   idx_err_o   : sticky row-index mismatch flag
module dq_tile_collector #(
  parameter int FP_DATA_W     = 32,
  parameter int LANES_NUM     = 16,
  parameter int ROW_W         = 4,
  parameter int ROWS_PER_TILE = 16,
  parameter int OUT_LANES     = 4,
  parameter int TILE_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear_i,
  dq_tile_collector_if.slave    bus,
  output logic                  tile_done_o,
  output logic [TILE_CNT_W-1:0] tile_cnt_o,
  output logic                  idx_err_o
);

  localparam int ROW_DATA_W = LANES_NUM * FP_DATA_W;
  localparam int BEAT_W     = OUT_LANES * FP_DATA_W;
  localparam int BEATS      = LANES_NUM / OUT_LANES;
  localparam int RW         = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS_PER_TILE - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state;
  logic [RW-1:0]       wr_row;
  logic [RW-1:0]       rd_row;
  logic [BW-1:0]       rd_beat;
  logic [ROW_W-1:0]    exp_idx;
  logic [ROW_DATA_W-1:0] tile_buf [ROWS_PER_TILE];
  logic [ROW_DATA_W-1:0] rd_row_data;
  logic [BEAT_W-1:0]   beat_sel [BEATS];

  // Handshake readiness is decoded from the state register only, so neither
  // s_valid_i nor m_ready_i has a combinational path to the opposite side.
  assign bus.s_ready_o = (state == FILL);
  assign bus.m_valid_o = (state == DRAIN);
  assign bus.m_last_o  = (state == DRAIN) && (rd_row == LAST_ROW) && (rd_beat == LAST_BEAT);

  // The output beat is muxed straight from the buffer. The read pointers
  // only move on a handshake, so the data holds while stalled.
  assign rd_row_data = tile_buf[rd_row];
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign beat_sel[b] = rd_row_data[b*BEAT_W +: BEAT_W];
  end
  assign bus.m_data_o = beat_sel[rd_beat];

  // The buffer has no reset. A cleared or discarded tile is simply
  // overwritten by the next fill.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.s_valid_i) begin
      tile_buf[wr_row] <= bus.s_data_i;
    end
  end

  // Control FSM. wr_row addresses the buffer. exp_idx tracks the global
  // index independently and keeps running across tile boundaries.
  always_ff @(posedge clk) begin
    if (!rstnn || clear_i) begin
      state       <= FILL;
      wr_row      <= '0;
      rd_row      <= '0;
      rd_beat     <= '0;
      exp_idx     <= '0;
      tile_done_o <= 1'b0;
      tile_cnt_o  <= '0;
      idx_err_o   <= 1'b0;
    end else begin
      tile_done_o <= 1'b0;
      case (state)
        FILL: begin
          if (bus.s_valid_i) begin
            if (bus.s_index_i != exp_idx) begin
              idx_err_o <= 1'b1;
            end
            exp_idx <= exp_idx + ROW_W'(1);
            if (wr_row == LAST_ROW) begin
              wr_row <= '0;
              state  <= DRAIN;
            end else begin
              wr_row <= wr_row + RW'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.m_ready_i) begin
            if (rd_beat == LAST_BEAT) begin
              rd_beat <= '0;
              if (rd_row == LAST_ROW) begin
                rd_row      <= '0;
                state       <= FILL;
                tile_done_o <= 1'b1;
                tile_cnt_o  <= tile_cnt_o + TILE_CNT_W'(1);
              end else begin
                rd_row <= rd_row + RW'(1);
              end
            end else begin
              rd_beat <= rd_beat + BW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_dq_tile_collector.sv
// tb_dq_tile_collector
//   Drives tiles of rows into dq_tile_collector. Each issued tile pushes its
//   expected beats onto a scoreboard queue. A negedge monitor pops and
//   compares every accepted beat, and also checks the tile_done pulse, stall
//   stability and FILL/DRAIN exclusivity.
module tb_dq_tile_collector;

  localparam int FPW    = 32;
  localparam int LN     = 16;
  localparam int RIW    = 4;
  localparam int RPT    = 16;
  localparam int OL     = 4;
  localparam int TCW    = 16;
  localparam int BEATS  = LN / OL;
  localparam int BEAT_W = OL * FPW;
  localparam int ROWD_W = LN * FPW;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic              last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rstnn;
  logic           clear_i;
  logic           tile_done_o;
  logic [TCW-1:0] tile_cnt_o;
  logic           idx_err_o;

  dq_tile_collector_if #(.FP_DATA_W(FPW), .LANES_NUM(LN), .ROW_W(RIW), .OUT_LANES(OL)) bus ();

  dq_tile_collector #(
    .FP_DATA_W(FPW), .LANES_NUM(LN), .ROW_W(RIW),
    .ROWS_PER_TILE(RPT), .OUT_LANES(OL), .TILE_CNT_W(TCW)
  ) dut (
    .clk(clk), .rstnn(rstnn), .clear_i(clear_i), .bus(bus),
    .tile_done_o(tile_done_o), .tile_cnt_o(tile_cnt_o), .idx_err_o(idx_err_o)
  );

  always #5 clk = ~clk;

  beat_t             exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                beats_total = 0;
  bit                mon_en = 1'b0;
  bit                done_pending = 1'b0;
  bit                prev_stall = 1'b0;
  logic [BEAT_W-1:0] held_data;
  logic [BEAT_W-1:0] beat5_cap = '0;
  bit                rdy_rand = 1'b0;
  logic              rdy_val = 1'b1;

  task automatic checkOutput(input string name, input logic [BEAT_W-1:0] act,
                             input logic [BEAT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FPW-1:0] laneVal(input int tag, input int r, input int k);
    return {8'(r), 8'(k), 8'(tag), 8'h00};
  endfunction

  // Expected beats of one tile: row-major, OL lanes per beat, low lane low.
  task automatic pushTile(input int tag);
    beat_t e;
    for (int r = 0; r < RPT; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int l = 0; l < OL; l++) e.data[l*FPW +: FPW] = laneVal(tag, r, b*OL + l);
        e.last = (r == RPT-1) && (b == BEATS-1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Sends one tile of rows. Row bad_row carries bad_idx as its index, and
  // the input idles for stall_cycles after row stall_after.
  task automatic applyStimulus(input int tag, input int bad_row, input int bad_idx,
                               input int stall_after, input int stall_cycles);
    logic [ROWD_W-1:0] d;
    int n;
    for (int r = 0; r < RPT; r++) begin
      for (int k = 0; k < LN; k++) d[k*FPW +: FPW] = laneVal(tag, r, k);
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = d;
      bus.s_index_i = (r == bad_row) ? RIW'(bad_idx) : RIW'(r);
      if (r == bad_row) checkOutput("idx_err_before", BEAT_W'(idx_err_o), BEAT_W'(0));
      if (bad_row >= 0 && r == bad_row + 1) checkOutput("idx_err_after", BEAT_W'(idx_err_o), BEAT_W'(1));
      n = 0;
      while (!bus.s_ready_o && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus.s_ready_o) checkOutput("s_ready_timeout", BEAT_W'(bus.s_ready_o), BEAT_W'(1));
      @(posedge clk); #1;
      if (r == stall_after) begin
        bus.s_valid_i = 1'b0;
        for (int i = 0; i < stall_cycles; i++) begin
          @(posedge clk); #1;
          checkOutput("fill_stall_idle", BEAT_W'(bus.m_valid_o), BEAT_W'(0));
        end
      end
    end
    bus.s_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", BEAT_W'(exp_q.size()), BEAT_W'(0));
      exp_q.delete();
    end
  endtask

  // Beat ready: either held at rdy_val or pseudo-random for backpressure.
  initial begin
    bus.m_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.m_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: a beat seen valid and ready at the negedge is taken at the
  // following posedge, so it is popped and scored here.
  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      checkOutput("tile_done", BEAT_W'(tile_done_o), BEAT_W'(done_pending));
      done_pending = 1'b0;
      if (bus.m_valid_o) begin
        checkOutput("exclusive_ready", BEAT_W'(bus.s_ready_o), BEAT_W'(0));
        if (prev_stall) checkOutput("stall_hold", bus.m_data_o, held_data);
        if (bus.m_ready_i) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", BEAT_W'(1), BEAT_W'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat_data", bus.m_data_o, e.data);
            checkOutput("beat_last", BEAT_W'(bus.m_last_o), BEAT_W'(e.last));
            if (beats_total == 5) beat5_cap = bus.m_data_o;
            beats_total++;
            if (e.last) done_pending = 1'b1;
          end
        end
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      held_data  = bus.m_data_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rstnn         = 1'b0;
    clear_i       = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_index_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", BEAT_W'(bus.s_ready_o), BEAT_W'(1));
    checkOutput("rst_m_valid", BEAT_W'(bus.m_valid_o), BEAT_W'(0));
    checkOutput("rst_m_last", BEAT_W'(bus.m_last_o), BEAT_W'(0));
    checkOutput("rst_tile_done", BEAT_W'(tile_done_o), BEAT_W'(0));
    checkOutput("rst_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(0));
    checkOutput("rst_idx_err", BEAT_W'(idx_err_o), BEAT_W'(0));
    rstnn  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] basic tile");
    pushTile(0);
    applyStimulus(0, -1, 0, -1, 0);
    waitDrain();
    checkOutput("basic_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(1));
    checkOutput("basic_idx_err", BEAT_W'(idx_err_o), BEAT_W'(0));
    checkOutput("basic_beat5", beat5_cap, 128'h01070000_01060000_01050000_01040000);

    $display("[TB] backpressure, indices wrap into second tile");
    rdy_rand = 1'b1;
    pushTile(1);
    applyStimulus(1, -1, 0, -1, 0);
    waitDrain();
    rdy_rand = 1'b0;
    checkOutput("wrap_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(2));
    checkOutput("wrap_idx_err", BEAT_W'(idx_err_o), BEAT_W'(0));

    $display("[TB] index mismatch on row 3");
    pushTile(2);
    applyStimulus(2, 3, 5, -1, 0);
    checkOutput("mismatch_held_fill", BEAT_W'(idx_err_o), BEAT_W'(1));
    waitDrain();
    checkOutput("mismatch_held_end", BEAT_W'(idx_err_o), BEAT_W'(1));
    checkOutput("mismatch_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(3));

    $display("[TB] clear after beat 10");
    pushTile(3);
    base = beats_total;
    applyStimulus(3, -1, 0, -1, 0);
    for (int i = 0; i < 500; i++) begin
      if (beats_total - base >= 11) break;
      @(posedge clk); #1;
    end
    checkOutput("clear_beats_seen", BEAT_W'(beats_total - base), BEAT_W'(11));
    clear_i = 1'b1;
    rdy_val = 1'b0;
    @(posedge clk); #1;
    clear_i = 1'b0;
    exp_q.delete();
    checkOutput("clear_m_valid", BEAT_W'(bus.m_valid_o), BEAT_W'(0));
    checkOutput("clear_s_ready", BEAT_W'(bus.s_ready_o), BEAT_W'(1));
    checkOutput("clear_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(0));
    checkOutput("clear_idx_err", BEAT_W'(idx_err_o), BEAT_W'(0));
    rdy_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] fresh tile with fill stall after row 7");
    pushTile(4);
    applyStimulus(4, -1, 0, 7, 20);
    waitDrain();
    checkOutput("fresh_tile_cnt", BEAT_W'(tile_cnt_o), BEAT_W'(1));
    checkOutput("fresh_idx_err", BEAT_W'(idx_err_o), BEAT_W'(0));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
